uart_apb_master: RTL
====================

UART_APB_MASTER -- requirements
Module: uart_apb_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, which is the maximum number of ACCESS cycles before a transfer is aborted (legal range 2..255).
REQ-002 SHALL have port PCLK, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port PRESET, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port cmd_valid, input, 1 bit: a command request is present.
REQ-005 SHALL have port cmd_ready, output, 1 bit: the block can accept a command.
REQ-006 SHALL have port cmd_write, input, 1 bit: 1 selects a write, 0 selects a read.
REQ-007 SHALL have port cmd_addr, input, 5 bits: the APB target address.
REQ-008 SHALL have port cmd_wdata, input, 32 bits: the write data.
REQ-009 SHALL have port rsp_valid, output, 1 bit: a response is present.
REQ-010 SHALL have port rsp_ready, input, 1 bit: the consumer accepts the response.
REQ-011 SHALL have port rsp_rdata, output, 32 bits: the read data.
REQ-012 SHALL have port rsp_error, output, 1 bit: the transfer timed out.
REQ-013 SHALL have ports PSEL, PENABLE and PWRITE, each an output of 1 bit: the APB requester controls.
REQ-014 SHALL have port PADDR, output, 5 bits, and port PWDATA, output, 32 bits.
REQ-015 SHALL have port PRDATA, input, 32 bits, and port PREADY, input, 1 bit.
REQ-016 SHALL have port busy, output, 1 bit: the FSM is not in IDLE.
REQ-017 SHALL have port timeout_count, output, 8 bits: a saturating count of timed-out transfers.

Function
REQ-018 SHALL implement the FSM states IDLE, SETUP, ACCESS and RESP; all outputs SHALL be registered or decoded from state only.
REQ-019 In IDLE: cmd_ready=1, PSEL=0, PENABLE=0; cmd_valid&&cmd_ready SHALL capture write, addr and wdata into PWRITE, PADDR and PWDATA, then go to SETUP.
REQ-020 In SETUP: PSEL=1, PENABLE=0 for exactly one cycle, then go to ACCESS.
REQ-021 In ACCESS: PSEL=1, PENABLE=1; the wait counter is cleared on entry.
REQ-022 PADDR, PWRITE and PWDATA SHALL be stable from SETUP through the end of ACCESS, and SHALL hold their last values in IDLE and RESP.
REQ-023 In ACCESS with PREADY=1: go to RESP with rsp_error=0; for a read, rsp_rdata=PRDATA sampled on that edge; for a write, rsp_rdata=0.
REQ-024 In ACCESS with PREADY=0: wait counter +1; if counter==TIMEOUT_CYCLES-1, go to RESP with rsp_error=1, rsp_rdata=0, and timeout_count +1 (saturating at 255).
REQ-025 PREADY=1 in the final permitted ACCESS cycle SHALL complete normally; no timeout is counted.
REQ-026 In RESP: rsp_valid=1, PSEL=0, PENABLE=0; rsp_rdata and rsp_error are held until rsp_valid&&rsp_ready, then go to IDLE.
REQ-027 cmd_ready SHALL be 0 in SETUP, ACCESS and RESP; there SHALL be no command accept in the cycle of a response handshake.
REQ-028 Zero-wait latency: command handshake at edge N, SETUP in cycle N+1, ACCESS in cycle N+2, rsp_valid=1 in cycle N+3.
REQ-029 The minimum spacing between command accepts SHALL be 4 cycles (IDLE, SETUP, ACCESS, RESP).
REQ-030 PRDATA and PREADY SHALL be ignored outside ACCESS.
REQ-031 PENABLE=1 SHALL never occur without PSEL=1; PENABLE SHALL never be asserted in the first cycle of PSEL.

Reset
REQ-032 PRESET=1 at a rising edge SHALL force IDLE and clear PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_error, the wait counter and timeout_count to 0; cmd_ready=1 and busy=0 in the first cycle after reset.
REQ-033 Reset in SETUP, ACCESS or RESP SHALL abort the transfer: no response is produced and the APB controls drop on that edge.
REQ-034 Reset SHALL have priority over all other events in the same cycle.

Verification
REQ-035 Write 0x0000_0003 to 0x00, PREADY=1 in the first ACCESS cycle -> SETUP then ACCESS with PWRITE=1, PADDR=0x00, PWDATA=0x3; rsp_valid=1, rsp_error=0 three cycles after the accept.
REQ-036 Read 0x08, PREADY low for 3 ACCESS cycles then high with PRDATA=0x0000_00A5 -> rsp_rdata=0xA5, rsp_error=0, PADDR stable throughout.
REQ-037 Read 0x0C, PREADY held 0 -> exactly 16 ACCESS cycles, then rsp_error=1, rsp_rdata=0, timeout_count=1.
REQ-038 PREADY=1 exactly in ACCESS cycle 16 -> normal completion, timeout_count unchanged.
REQ-039 rsp_ready held 0 for 5 cycles -> rsp_valid and data held, cmd_ready=0, and a pending cmd_valid is not accepted until 1 cycle after the response handshake.
REQ-040 PRESET pulsed mid-ACCESS -> PSEL=PENABLE=0 on the next cycle, no rsp_valid, timeout_count=0, and the next command completes normally.

Source files
------------

// File: rtl/uart_apb_master.sv
// uart_apb_master
// Turns single-beat command requests into APB transfers and hands back one
// response per command. A transfer that sees no PREADY within TIMEOUT_CYCLES
// ACCESS cycles is aborted with rsp_error set and counted in timeout_count.
//
// Ports
//   PCLK, PRESET                     clock, synchronous active-high reset
//   cmd_valid/cmd_ready              command handshake
//   cmd_write, cmd_addr, cmd_wdata   command payload (1 = write)
//   rsp_valid/rsp_ready              response handshake
//   rsp_rdata, rsp_error             read data (0 for writes/timeouts), timeout flag
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA, PRDATA, PREADY   APB requester side
//   busy                             FSM not in IDLE
//   timeout_count                    saturating count of timed-out transfers
//
// state  | meaning
// IDLE   | ready for a command
// SETUP  | APB setup phase, PSEL only
// ACCESS | APB access phase, waiting for PREADY or timeout
// RESP   | response presented until rsp_ready
module uart_apb_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [4:0]  PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    output logic        busy,
    output logic [7:0]  timeout_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    // Counter value seen during the last permitted ACCESS cycle.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic       access_timeout;

    assign access_timeout = (state == S_ACCESS) && !PREADY && (wait_cnt == LAST_WAIT);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (cmd_valid) state_nxt = S_SETUP;
            S_SETUP:  state_nxt = S_ACCESS;
            S_ACCESS: if (PREADY || access_timeout) state_nxt = S_RESP;
            S_RESP:   if (rsp_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state         <= S_IDLE;
            PWRITE        <= 1'b0;
            PADDR         <= '0;
            PWDATA        <= '0;
            rsp_rdata     <= '0;
            rsp_error     <= 1'b0;
            wait_cnt      <= '0;
            timeout_count <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        PWRITE <= cmd_write;
                        PADDR  <= cmd_addr;
                        PWDATA <= cmd_wdata;
                    end
                end
                S_SETUP: wait_cnt <= '0;
                S_ACCESS: begin
                    if (PREADY) begin
                        rsp_error <= 1'b0;
                        rsp_rdata <= PWRITE ? 32'd0 : PRDATA;
                    end else if (access_timeout) begin
                        rsp_error <= 1'b1;
                        rsp_rdata <= 32'd0;
                        if (timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // All handshake and APB controls are pure state decodes.
    assign cmd_ready = (state == S_IDLE);
    assign PSEL      = (state == S_SETUP) || (state == S_ACCESS);
    assign PENABLE   = (state == S_ACCESS);
    assign rsp_valid = (state == S_RESP);
    assign busy      = (state != S_IDLE);

endmodule
